// File: rtl/gaussian_stream_filter.sv
// gaussian_stream_filter: streaming 3x3 Gaussian filter for raster-ordered pixels.
// Two line buffers hold the previous two rows; a 3x3 window is built from two
// registered columns plus the column arriving with the current input pixel.
// Output (r,c) is produced when input (r+1,c+1) is accepted; the last IMG_W+1
// outputs of a frame are generated in FLUSH with no input.
// Build option: define GAUSS_REPLICATE_EN for edge-replicate borders; the
// default build uses zero padding for out-of-image taps.
module gaussian_stream_filter #(
    parameter int PIX_W      = 8,
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int COEF_W     = 8,
    parameter int K_CORNER   = 3,
    parameter int K_EDGE     = 21,
    parameter int K_CENTER   = 158,
    parameter int NORM_SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_eol,
    output logic             m_last,
    output logic [1:0]       dbg_state
);
    localparam int PROD_W = PIX_W + COEF_W;
    localparam int ACC_W  = PIX_W + COEF_W + 4;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ACC_W:0]    RND_HALF = (ACC_W + 1)'(1) << (NORM_SHIFT - 1);
    localparam logic [COEF_W-1:0] C_CORNER = COEF_W'(K_CORNER);
    localparam logic [COEF_W-1:0] C_EDGE   = COEF_W'(K_EDGE);
    localparam logic [COEF_W-1:0] C_CENTER = COEF_W'(K_CENTER);

    typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    state_t           state, state_nx;
    logic             started;
    logic [COL_W-1:0] in_col, out_col;
    logic [ROW_W-1:0] in_row, out_row;
    logic             slot_free, in_xfer, produce, step;
    logic             top_ok, bot_ok, left_ok, right_ok;

    logic [PIX_W-1:0] lb0 [IMG_W];   // row just above the incoming row
    logic [PIX_W-1:0] lb1 [IMG_W];   // row two above the incoming row
    logic [PIX_W-1:0] win_l [3];     // window left column, index 0 = top
    logic [PIX_W-1:0] win_c [3];     // window centre column
    logic [PIX_W-1:0] col_new [3];   // window right column, taken from this cycle's input
    logic [PIX_W-1:0] raw [3][3];    // [row][col]
    logic [PIX_W-1:0] tap [3][3];
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   rounded, shifted;
    logic [PIX_W-1:0] result;

    // Handshake: a transfer happens on a cycle where valid && ready; the sender
    // holds data stable while valid && !ready. The output stage is one register,
    // so a new pixel may be loaded in the same cycle the current one leaves.
    assign slot_free = !m_valid || m_ready;
    assign s_ready   = started && (state != FLUSH) && slot_free;
    assign in_xfer   = s_valid && s_ready;
    assign produce   = ((state == RUN) && in_xfer) || ((state == FLUSH) && slot_free);
    assign step      = in_xfer || ((state == FLUSH) && slot_free);
    assign dbg_state = state;

    assign top_ok   = (out_row != '0);
    assign bot_ok   = (out_row != ROW_LAST);
    assign left_ok  = (out_col != '0);
    assign right_ok = (out_col != COL_LAST);

    // Column entering the window: two buffered rows plus the new pixel (none in FLUSH).
    always_comb begin
        col_new[0] = lb1[in_col];
        col_new[1] = lb0[in_col];
        col_new[2] = (state == FLUSH) ? '0 : s_data;
        for (int r = 0; r < 3; r++) begin
            raw[r][0] = win_l[r];
            raw[r][1] = win_c[r];
            raw[r][2] = col_new[r];
        end
    end

    // Border handling: replace taps that fall outside the image.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
`ifdef GAUSS_REPLICATE_EN
                tap[r][c] = raw[((r == 0 && !top_ok) || (r == 2 && !bot_ok)) ? 1 : r]
                               [((c == 0 && !left_ok) || (c == 2 && !right_ok)) ? 1 : c];
`else
                tap[r][c] = ((r == 0 && !top_ok) || (r == 2 && !bot_ok) ||
                             (c == 0 && !left_ok) || (c == 2 && !right_ok)) ? '0 : raw[r][c];
`endif
            end
        end
    end

    // Weighted sum, rounding, normalisation and saturation.
    always_comb begin
        acc = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                acc = acc + ACC_W'(PROD_W'(tap[r][c]) *
                      PROD_W'(((r == 1) && (c == 1)) ? C_CENTER :
                              ((r == 1) || (c == 1)) ? C_EDGE : C_CORNER));
            end
        end
        rounded = {1'b0, acc} + RND_HALF;
        shifted = rounded >> NORM_SHIFT;
        result  = (|shifted[ACC_W:PIX_W]) ? '1 : shifted[PIX_W-1:0];
    end

    // Next-state logic for the FILL / RUN / FLUSH sequencing.
    always_comb begin
        state_nx = state;
        case (state)
            FILL:    if (in_xfer && in_row == ROW_W'(1) && in_col == '0) state_nx = RUN;
            RUN:     if (in_xfer && in_row == ROW_LAST && in_col == COL_LAST) state_nx = FLUSH;
            FLUSH:   if (produce && out_row == ROW_LAST && out_col == COL_LAST) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    // State, position counters and window column shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            started <= 1'b0;
            in_col  <= '0;
            in_row  <= '0;
            out_col <= '0;
            out_row <= '0;
            for (int r = 0; r < 3; r++) begin
                win_l[r] <= '0;
                win_c[r] <= '0;
            end
        end else begin
            state   <= state_nx;
            started <= 1'b1;
            if (step) begin
                for (int r = 0; r < 3; r++) begin
                    win_l[r] <= win_c[r];
                    win_c[r] <= col_new[r];
                end
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    if (state != FLUSH) in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end
            if (produce) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end
            // FLUSH walks a virtual row past the image; realign for the next frame.
            if (state == FLUSH && state_nx == FILL) in_col <= '0;
        end
    end

    // Line buffers shift one row down on every accepted pixel; contents need no reset.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            lb1[in_col] <= lb0[in_col];
            lb0[in_col] <= s_data;
        end
    end

    // Single-stage output register, held while the downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_eol   <= 1'b0;
            m_last  <= 1'b0;
        end else if (produce) begin
            m_valid <= 1'b1;
            m_data  <= result;
            m_eol   <= (out_col == COL_LAST);
            m_last  <= (out_col == COL_LAST) && (out_row == ROW_LAST);
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gaussian_stream_filter.sv
// tb_gaussian_stream_filter: randomized and directed frames on a 4x4 image,
// outputs compared against a pixel-level reference of the 3x3 Gaussian.
`timescale 1ns/1ps
module tb_gaussian_stream_filter;
  localparam int PIX_W      = 8;
  localparam int IMG_W      = 4;
  localparam int IMG_H      = 4;
  localparam int NPIX       = IMG_W * IMG_H;
  localparam int K_CORNER   = 3;
  localparam int K_EDGE     = 21;
  localparam int K_CENTER   = 158;
  localparam int NORM_SHIFT = 8;
  localparam int EW         = PIX_W + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [PIX_W-1:0] s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [PIX_W-1:0] m_data;
  logic             m_eol;
  logic             m_last;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];
  logic [PIX_W-1:0] frame_px [NPIX];
  bit mon_en = 1'b0;
  bit count_lows = 1'b0;
  int out_seen = 0;
  int low_cnt = 0;

  gaussian_stream_filter #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .COEF_W(8),
    .K_CORNER(K_CORNER), .K_EDGE(K_EDGE), .K_CENTER(K_CENTER), .NORM_SHIFT(NORM_SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_eol(m_eol), .m_last(m_last), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: pixel with border rule, then weighted 3x3 sum
  function automatic int px_at(int r, int c);
`ifdef GAUSS_REPLICATE_EN
    if (r < 0) r = 0;
    if (r >= IMG_H) r = IMG_H - 1;
    if (c < 0) c = 0;
    if (c >= IMG_W) c = IMG_W - 1;
    return int'(frame_px[r * IMG_W + c]);
`else
    if (r < 0 || r >= IMG_H || c < 0 || c >= IMG_W) return 0;
    return int'(frame_px[r * IMG_W + c]);
`endif
  endfunction

  function automatic int model_out(int r, int c);
    int acc = 0;
    int w;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr == 0 && dc == 0) w = K_CENTER;
        else if (dr == 0 || dc == 0) w = K_EDGE;
        else w = K_CORNER;
        acc += w * px_at(r + dr, c + dc);
      end
    end
    acc = (acc + (1 << (NORM_SHIFT - 1))) >> NORM_SHIFT;
    if (acc > (1 << PIX_W) - 1) acc = (1 << PIX_W) - 1;
    return acc;
  endfunction

  task automatic push_expect();
    logic [31:0] v;
    bit eo, la;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        v  = 32'(model_out(r, c));
        eo = (c == IMG_W - 1);
        la = (c == IMG_W - 1) && (r == IMG_H - 1);
        exp_q.push_back({la, eo, v[PIX_W-1:0]});
      end
    end
  endtask

  // scoreboard monitor: one comparison per output transfer
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (mon_en && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_seen), 32'(-1));
      end else begin
        e = exp_q.pop_front();
        check("out_pixel", 32'({m_last, m_eol, m_data}), 32'(e));
      end
      out_seen++;
    end
  end

  always @(negedge clk) begin
    if (count_lows && s_valid && !s_ready) low_cnt++;
  end

  // driver tasks
  task automatic send_pixels(input int n, input bit gaps, input bit hold_end);
    int waited;
    for (int i = 0; i < n; i++) begin
      waited  = 0;
      s_data  = frame_px[i];
      s_valid = 1'b1;
      @(negedge clk);
      while (!s_ready && waited < 500) begin
        waited++;
        @(negedge clk);
      end
      if (!s_ready) begin
        check("s_ready_timeout", 32'(i), 32'(-1));
        s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    if (!hold_end) s_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready with a 5-cycle stall mid-frame
  task automatic drive_ready(input int mode, input int target);
    int cycles = 0;
    bit stalled = 1'b0;
    while (out_seen < target && cycles < 3000) begin
      if (mode == 2 && !stalled && out_seen >= target - NPIX + 6 && m_valid) begin
        stalled = 1'b1;
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_m_valid", 32'(m_valid), 32'd1);
          check("stall_s_ready", 32'(s_ready), 32'd0);
          if (exp_q.size() == 0) check("stall_exp_empty", 32'(0), 32'(1));
          else check("stall_m_data", 32'({m_last, m_eol, m_data}), 32'(exp_q[0]));
          @(posedge clk);
          #1;
        end
      end
      m_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (out_seen < target) check("output_timeout", 32'(out_seen), 32'(target));
    m_ready = 1'b1;
  endtask

  task automatic run_frame(input bit gaps, input int mode);
    int target;
    push_expect();
    target = out_seen + NPIX;
    fork
      send_pixels(NPIX, gaps, 1'b0);
      drive_ready(mode, target);
    join
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < NPIX; i++) frame_px[i] = PIX_W'(v);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) frame_px[i] = PIX_W'($urandom_range(0, 255));
  endtask

  // main sequence
  initial begin
    int target;
    int lows0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_eol", 32'(m_eol), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("s_ready_after_rst", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    mon_en  = 1'b1;
    m_ready = 1'b1;

    fill_const(100);
    run_frame(1'b0, 0);

    fill_const(0);
    frame_px[1 * IMG_W + 1] = 8'd255;
    run_frame(1'b0, 0);

    fill_const(255);
    run_frame(1'b0, 1);

    for (int f = 0; f < 3; f++) begin
      fill_random();
      run_frame(1'b1, 1);
    end

    fill_random();
    run_frame(1'b0, 2);

    // back-to-back frames with s_valid held
    fill_random();
    push_expect();
    push_expect();
    target     = out_seen + 2 * NPIX;
    lows0      = low_cnt;
    count_lows = 1'b1;
    fork
      begin
        send_pixels(NPIX, 1'b0, 1'b1);
        send_pixels(NPIX, 1'b0, 1'b0);
      end
      drive_ready(0, target);
    join
    count_lows = 1'b0;
    check("b2b_flush_ready_low", 32'(low_cnt - lows0), 32'd5);

    // reset mid-frame after the 7th input transfer
    fill_random();
    mon_en  = 1'b0;
    m_ready = 1'b1;
    send_pixels(7, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_m_valid", 32'(m_valid), 32'd0);
    check("rst_mid_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    check("rst_mid_s_ready_next", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    exp_q.delete();
    mon_en = 1'b1;
    fill_random();
    run_frame(1'b1, 1);

    repeat (3) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
